// File: rtl/micro_cnt_checker.sv
// micro_cnt_checker: locks onto a free-running 8-bit counter stream on ui_in,
// checks that every value is the previous one plus one (mod 256), and reports
// lock state, a sticky error flag and a saturating error count on uo_out.
// While rst is high, uo_out loops ui_in straight back for board-level checks.
module micro_cnt_checker #(
  parameter int LOCK_LEN = 4  // consecutive matches in ACQ before LOCK, 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACQ  = 2'b01,
    LOCK = 2'b10
  } state_t;

  // Match count at which the next match completes acquisition.
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_LEN - 1);

  state_t     state_q,      state_d;
  logic [7:0] expected_q,   expected_d;
  logic [3:0] match_cnt_q,  match_cnt_d;
  logic [3:0] err_cnt_q,    err_cnt_d;
  logic       err_sticky_q, err_sticky_d;

  logic [7:0] next_exp_s;
  logic       match_s;
  logic [7:0] status_s;

  assign next_exp_s = ui_in + 8'd1;
  assign match_s    = (ui_in == expected_q);

  // State register; reset wins over any FSM action on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      expected_q   <= 8'h00;
      match_cnt_q  <= 4'h0;
      err_cnt_q    <= 4'h0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      match_cnt_q  <= match_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // Next-state logic: seed, acquire, track, and count errors only when locked.
  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    match_cnt_d  = match_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    case (state_q)
      IDLE: begin
        expected_d  = next_exp_s;
        match_cnt_d = 4'h0;
        state_d     = ACQ;
      end
      ACQ: begin
        // Every sample reseeds the prediction; only the match counter differs.
        expected_d = next_exp_s;
        if (match_s) begin
          if (match_cnt_q == LOCK_LAST) begin
            state_d     = LOCK;
            match_cnt_d = 4'h0;
          end else begin
            match_cnt_d = match_cnt_q + 4'h1;
          end
        end else begin
          match_cnt_d = 4'h0;
        end
      end
      LOCK: begin
        expected_d = next_exp_s;
        if (match_s) begin
          state_d = LOCK;
        end else begin
          if (err_cnt_q != 4'hF) begin
            err_cnt_d = err_cnt_q + 4'h1;
          end else begin
            err_cnt_d = err_cnt_q;
          end
          err_sticky_d = 1'b1;
          match_cnt_d  = 4'h0;
          state_d      = ACQ;
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean start.
        state_d     = IDLE;
        expected_d  = 8'h00;
        match_cnt_d = 4'h0;
      end
    endcase
  end

  // Status word built purely from registered state.
  always_comb begin
    status_s = {err_cnt_q, state_q, err_sticky_q, (state_q == LOCK)};
  end

  // Output mux: loopback during reset is the only combinational input path.
  always_comb begin
    if (rst) begin
      uo_out = ui_in;
    end else begin
      uo_out = status_s;
    end
  end

endmodule

// File: tb/tb_micro_cnt_checker.sv
// Directed self-checking bench for micro_cnt_checker with LOCK_LEN = 4.
module tb_micro_cnt_checker;

  logic       clk;
  logic       rst;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  int checks_cnt;
  int errors_cnt;

  micro_cnt_checker #(.LOCK_LEN(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .ui_in  (ui_in),
    .uo_out (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed byte against its expected value.
  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Apply one sample, clock it in, and settle just after the edge.
  task automatic step(input logic [7:0] v);
    ui_in = v;
    @(posedge clk);
    #1;
  endtask

  // One reset edge followed by release.
  task automatic do_reset();
    rst = 1'b1;
    ui_in = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  logic [7:0] v;
  logic [7:0] base;
  logic [3:0] exp_err;

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst   = 1'b1;
    ui_in = 8'hA5;

    // 1. Reset loopback and release.
    repeat (2) @(posedge clk);
    #1;
    check_eq("loop_a5", uo_out, 8'hA5);
    ui_in = 8'h3C;
    #1;
    check_eq("loop_3c", uo_out, 8'h3C);
    rst = 1'b0;
    #1;
    check_eq("release", uo_out, 8'h00);

    // 2. Lock acquisition: seed then four matches.
    step(8'h10);
    check_eq("seed", uo_out, 8'h04);
    step(8'h11); check_eq("acq_11", uo_out, 8'h04);
    step(8'h12); check_eq("acq_12", uo_out, 8'h04);
    step(8'h13); check_eq("acq_13", uo_out, 8'h04);
    step(8'h14); check_eq("lock_14", uo_out, 8'h09);

    // 3. Wrap: relock just below 0xFF then run across the wrap.
    do_reset();
    check_eq("rst2_rel", uo_out, 8'h00);
    step(8'hF8); step(8'hF9); step(8'hFA); step(8'hFB);
    check_eq("acq_fb", uo_out, 8'h04);
    step(8'hFC); check_eq("lock_fc", uo_out, 8'h09);
    step(8'hFD); check_eq("wrap_fd", uo_out, 8'h09);
    step(8'hFE); check_eq("wrap_fe", uo_out, 8'h09);
    step(8'hFF); check_eq("wrap_ff", uo_out, 8'h09);
    step(8'h00); check_eq("wrap_00", uo_out, 8'h09);
    step(8'h01); check_eq("wrap_01", uo_out, 8'h09);

    // 4. Glitch and relock.
    step(8'h02); step(8'h03);
    check_eq("pre_glitch", uo_out, 8'h09);
    step(8'h55); check_eq("glitch_55", uo_out, 8'h16);
    step(8'h56); step(8'h57); step(8'h58);
    check_eq("reacq_58", uo_out, 8'h16);
    step(8'h59); check_eq("relock_59", uo_out, 8'h1B);

    // 5. ACQ noise: steps of 3 never look like an increment.
    do_reset();
    v = 8'h07;
    for (int i = 0; i < 20; i++) begin
      step(v);
      check_eq("noise", uo_out, 8'h04);
      v = v + 8'd3;
    end

    // 6. Saturation: lock, then 17 glitch/relock rounds.
    step(v); v = v + 8'd1;
    for (int i = 0; i < 4; i++) begin
      step(v);
      v = v + 8'd1;
    end
    check_eq("sat_lock", uo_out, 8'h09);
    exp_err = 4'h0;
    for (int g = 0; g < 17; g++) begin
      base = v + 8'h40;
      step(base);
      if (exp_err != 4'hF) exp_err = exp_err + 4'h1;
      check_eq("sat_glitch", uo_out, {exp_err, 2'b01, 1'b1, 1'b0});
      v = base + 8'd1;
      for (int i = 0; i < 4; i++) begin
        step(v);
        v = v + 8'd1;
      end
      check_eq("sat_relock", uo_out, {exp_err, 2'b10, 1'b1, 1'b1});
    end
    check_eq("sat_final", uo_out, 8'hFB);

    // Reset mid-operation with a mismatching sample on the same edge.
    rst   = 1'b1;
    ui_in = 8'h77;
    @(posedge clk);
    #1;
    check_eq("mid_rst_loop", uo_out, 8'h77);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_rel", uo_out, 8'h00);
    v = 8'h30;
    step(v); check_eq("post_seed", uo_out, 8'h04);
    for (int i = 0; i < 4; i++) begin
      v = v + 8'd1;
      step(v);
    end
    check_eq("post_lock", uo_out, 8'h09);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
